// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Multiplexed common-anode seven-segment display driver. It steps through
// NUM_DIGITS digits, one slot of 2^DIV_WIDTH clkin cycles each. A hex nibble
// per digit is decoded to active-low segments. The driver also supports a
// decimal point per digit, blanking per digit, PWM brightness, a scan enable
// and a frame snapshot. The snapshot keeps each frame tear-free.
//
// Ports
//   clkin       system clock (rising edge)
//   reset       synchronous active-high reset
//   enable      scan enable; low freezes the scan and darkens the display
//   digits_in   hex nibble per digit, digit k = bits [4k+3:4k]
//   dp_in       decimal point request per digit (1 = lit)
//   blank_in    per-digit blank (1 = dark)
//   brightness  PWM level, sampled live every cycle
//   an          anode drives, active low
//   seg         segments {g,f,e,d,c,b,a}, active low
//   dp          decimal point, active low
//   digit_idx   index of the digit whose slot is active
//   frame_tick  one-cycle pulse after each frame wrap
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int BRIGHT_WIDTH = 4,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [BRIGHT_WIDTH-1:0] brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam logic [DIV_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0]    cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] snap_dig_p0;
  logic [NUM_DIGITS-1:0]   snap_dp_p0;
  logic [NUM_DIGITS-1:0]   snap_blank_p0;

  logic                    wrap_slot;
  logic                    wrap_frame;
  logic                    lit;
  logic [3:0]              nib;
  logic                    dp_sel;
  logic                    blank_sel;
  logic [NUM_DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign wrap_slot  = (cnt_p0 == CNT_MAX);
  assign wrap_frame = enable && wrap_slot && (idx_p0 == IDX_LAST);

  // Select the snapshot fields of the active digit. Unused index codes
  // (non-power-of-2 digit counts) are never reached and fall to defaults.
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_p0 == IDX_W'(k)) begin
        nib       = snap_dig_p0[4*k +: 4];
        dp_sel    = snap_dp_p0[k];
        blank_sel = snap_blank_p0[k];
      end
    end
  end

  // The PWM on-window compares the top bits of the slot counter with the
  // live brightness. The all-ones level therefore covers the whole slot.
  assign lit = enable && !blank_sel &&
               (cnt_p0[DIV_WIDTH-1 -: BRIGHT_WIDTH] <= brightness);

  always_comb begin
    an_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lit && (idx_p0 == IDX_W'(k))) an_nxt[k] = 1'b0;
    end
  end

  // Stage 0: slot prescaler, digit index and frame snapshot
  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (enable) begin
      cnt_p0 <= cnt_p0 + DIV_WIDTH'(1);
      if (wrap_slot) begin
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
      end
    end
  end

  // The snapshot also loads during reset. This lets the first frame after
  // reset show the inputs present while reset was held.
  always_ff @(posedge clkin) begin
    if (reset || wrap_frame) begin
      snap_dig_p0   <= digits_in;
      snap_dp_p0    <= dp_in;
      snap_blank_p0 <= blank_in;
    end
  end

  // Stage 1: registered display outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= lit ? hex_to_seg(nib) : 7'h7F;
      dp         <= lit ? ~dp_sel : 1'b1;
      frame_tick <= wrap_frame;
    end
  end

  assign digit_idx = idx_p0;

endmodule
